// File: rtl/accum_block_dispatcher_pkg.sv
// Shared constants and FSM state encoding for the accumulation block dispatcher.
// Pure declarations: no latency, no flow control.
package accum_block_dispatcher_pkg;

    localparam int WORK_BW = 32;
    localparam int VDIM    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/accum_block_dispatcher_odometer.sv
// Row-major block-offset odometer: next offset, per-dim carry, and final-block flag.
// Purely combinational (0 cycles); no flow control.
module block_ofs_odometer
#(
    parameter int WBW  = accum_block_dispatcher_pkg::WORK_BW,
    parameter int VDIM = accum_block_dispatcher_pkg::VDIM
)
(
    input  logic [VDIM-1:0][WBW-1:0] i_ofs,
    input  logic [VDIM-1:0][WBW-1:0] i_step,
    input  logic [VDIM-1:0][WBW-1:0] i_end,
    output logic [VDIM-1:0][WBW-1:0] o_nxt_ofs,
    output logic                     o_last
);
    import accum_block_dispatcher_pkg::*;

    logic [VDIM-1:0] wrap;
    logic [VDIM-1:0] carry_in;

    for (genvar d = 0; d < VDIM; d++) begin : g_dim
        logic [WBW-1:0] eff_step;
        logic [WBW:0]   sum;

        // A zero stride collapses the dimension to a single block.
        assign eff_step = (i_step[d] == '0) ? i_end[d] : i_step[d];
        assign sum      = {1'b0, i_ofs[d]} + {1'b0, eff_step};
        assign wrap[d]  = (sum >= {1'b0, i_end[d]});

        if (d == VDIM - 1) begin : g_lsd
            assign carry_in[d] = 1'b1;
        end else begin : g_upper
            assign carry_in[d] = carry_in[d+1] & wrap[d+1];
        end

        assign o_nxt_ofs[d] = !carry_in[d] ? i_ofs[d] :
                              (wrap[d] ? '0 : sum[WBW-1:0]);
    end

    assign o_last = &wrap;

endmodule

// File: rtl/accum_block_dispatcher.sv
// Walks a block grid per job, issuing offsets to the looper under an in-flight credit limit.
// Config accept is combinational in IDLE; blk_rdy drops when MAX_INFLIGHT blocks are outstanding.
module accum_block_dispatcher
#(
    parameter int WBW          = accum_block_dispatcher_pkg::WORK_BW,
    parameter int VDIM         = accum_block_dispatcher_pkg::VDIM,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_BW       = $clog2(MAX_INFLIGHT + 1)
)
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     cfg_rdy,
    output logic                     cfg_ack,
    input  logic [VDIM-1:0][WBW-1:0] i_bgrid_step,
    input  logic [VDIM-1:0][WBW-1:0] i_bgrid_end,
    output logic                     blk_rdy,
    input  logic                     blk_ack,
    output logic [VDIM-1:0][WBW-1:0] o_bofs,
    output logic                     o_blk_last,
    input  logic                     blkdone_dval,
    output logic                     done_dval,
    output logic [CNT_BW-1:0]        o_inflight,
    output logic                     o_busy,
    output logic                     o_err
);
    import accum_block_dispatcher_pkg::*;

    state_e                  state_q, state_d;
    logic [VDIM-1:0][WBW-1:0] bofs_q, bofs_d;
    logic [VDIM-1:0][WBW-1:0] step_q, step_d;
    logic [VDIM-1:0][WBW-1:0] end_q, end_d;
    logic [CNT_BW-1:0]       inflight_q, inflight_d;
    logic                    err_q, err_d;

    logic [VDIM-1:0][WBW-1:0] nxt_bofs;
    logic                    odo_last;
    logic                    blk_hs;
    logic                    any_end_zero;

    block_ofs_odometer #(
        .WBW  (WBW),
        .VDIM (VDIM)
    ) u_odometer (
        .i_ofs     (bofs_q),
        .i_step    (step_q),
        .i_end     (end_q),
        .o_nxt_ofs (nxt_bofs),
        .o_last    (odo_last)
    );

    assign cfg_ack = (state_q == ST_IDLE) && cfg_rdy;
    assign blk_rdy = (state_q == ST_ISSUE) && (inflight_q < CNT_BW'(MAX_INFLIGHT));
    assign blk_hs  = blk_rdy && blk_ack;

    always_comb begin
        any_end_zero = 1'b0;
        for (int d = 0; d < VDIM; d++) begin
            if (i_bgrid_end[d] == '0) begin
                any_end_zero = 1'b1;
            end
        end
    end

    // Issue and retire in the same cycle cancel; a retire with nothing outstanding is an error.
    always_comb begin
        inflight_d = inflight_q;
        err_d      = err_q;
        if (blk_hs && !blkdone_dval) begin
            inflight_d = inflight_q + CNT_BW'(1);
        end else if (!blk_hs && blkdone_dval) begin
            if (inflight_q == '0) begin
                err_d = 1'b1;
            end else begin
                inflight_d = inflight_q - CNT_BW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bofs_d  = bofs_q;
        step_d  = step_q;
        end_d   = end_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_ack) begin
                    step_d  = i_bgrid_step;
                    end_d   = i_bgrid_end;
                    bofs_d  = '0;
                    state_d = any_end_zero ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (blk_hs) begin
                    if (odo_last) begin
                        state_d = ST_DRAIN;
                    end else begin
                        bofs_d = nxt_bofs;
                    end
                end
            end
            ST_DRAIN: begin
                if (inflight_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            bofs_q     <= '0;
            step_q     <= '0;
            end_q      <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bofs_q     <= bofs_d;
            step_q     <= step_d;
            end_q      <= end_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign o_bofs     = bofs_q;
    assign o_blk_last = (state_q == ST_ISSUE) && odo_last;
    assign done_dval  = (state_q == ST_DONE);
    assign o_inflight = inflight_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_err      = err_q;

endmodule

// File: tb/tb_accum_block_dispatcher.sv
// Scoreboard bench for accum_block_dispatcher: directed jobs, expected offsets queued,
// a negedge monitor checks every block handshake and counts done pulses.
module tb_accum_block_dispatcher;

    localparam int WBW    = 32;
    localparam int VDIM   = 2;
    localparam int MAXI   = 2;
    localparam int CNT_BW = 2;

    logic                     i_clk = 1'b0;
    logic                     i_rst;
    logic                     cfg_rdy;
    logic                     cfg_ack;
    logic [VDIM-1:0][WBW-1:0] i_bgrid_step;
    logic [VDIM-1:0][WBW-1:0] i_bgrid_end;
    logic                     blk_rdy;
    logic                     blk_ack;
    logic [VDIM-1:0][WBW-1:0] o_bofs;
    logic                     o_blk_last;
    logic                     blkdone_dval;
    logic                     done_dval;
    logic [CNT_BW-1:0]        o_inflight;
    logic                     o_busy;
    logic                     o_err;

    typedef struct {
        logic [WBW-1:0] b0;
        logic [WBW-1:0] b1;
        logic           last;
    } exp_t;

    exp_t exp_q[$];
    int   ret_q[$];
    int   cyc        = 0;
    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   hs_count   = 0;
    int   dones_seen = 0;
    int   jobs_exp   = 0;
    logic ack_en     = 1'b0;
    logic auto_ret   = 1'b0;
    logic track      = 1'b0;
    logic auto_done  = 1'b0;
    logic man_done   = 1'b0;

    assign blk_ack      = ack_en;
    assign blkdone_dval = auto_done | man_done;

    always #5 i_clk = ~i_clk;

    accum_block_dispatcher #(
        .WBW          (WBW),
        .VDIM         (VDIM),
        .MAX_INFLIGHT (MAXI),
        .CNT_BW       (CNT_BW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .cfg_rdy      (cfg_rdy),
        .cfg_ack      (cfg_ack),
        .i_bgrid_step (i_bgrid_step),
        .i_bgrid_end  (i_bgrid_end),
        .blk_rdy      (blk_rdy),
        .blk_ack      (blk_ack),
        .o_bofs       (o_bofs),
        .o_blk_last   (o_blk_last),
        .blkdone_dval (blkdone_dval),
        .done_dval    (done_dval),
        .o_inflight   (o_inflight),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    always @(posedge i_clk) cyc = cyc + 1;

    // Looper retire model: each tracked block retires 3 cycles after its ack.
    always @(posedge i_clk) begin
        #2;
        auto_done = 1'b0;
        if (auto_ret && ret_q.size() > 0 && ret_q[0] <= cyc) begin
            void'(ret_q.pop_front());
            auto_done = 1'b1;
        end
    end

    always @(negedge i_clk) begin
        if (!i_rst && blk_rdy && blk_ack) begin
            hs_count = hs_count + 1;
            if (track) ret_q.push_back(cyc + 3);
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL blk_unexpected got=(%0d,%0d) last=%0b required=no block",
                         o_bofs[0], o_bofs[1], o_blk_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (o_bofs[0] !== e.b0 || o_bofs[1] !== e.b1 || o_blk_last !== e.last) begin
                    n_bad = n_bad + 1;
                    $display("FAIL blk_ofs got=(%0d,%0d) last=%0b required=(%0d,%0d) last=%0b",
                             o_bofs[0], o_bofs[1], o_blk_last, e.b0, e.b1, e.last);
                end
            end
        end
        if (!i_rst && done_dval) dones_seen = dones_seen + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_exp(input int b0, input int b1, input logic last);
        exp_t e;
        e.b0   = WBW'(b0);
        e.b1   = WBW'(b1);
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic start_job(input int e0, input int e1, input int s0, input int s1);
        int k;
        k = 0;
        while (o_busy && k < 200) begin
            tick();
            k++;
        end
        chk("idle_before_cfg", o_busy, 0);
        i_bgrid_end[0]  = WBW'(e0);
        i_bgrid_end[1]  = WBW'(e1);
        i_bgrid_step[0] = WBW'(s0);
        i_bgrid_step[1] = WBW'(s1);
        cfg_rdy = 1'b1;
        #1;
        chk("cfg_ack", cfg_ack, 1);
        tick();
        cfg_rdy  = 1'b0;
        jobs_exp = jobs_exp + 1;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (dones_seen < jobs_exp && k < 400) begin
            tick();
            k++;
        end
        chk("done_count", dones_seen, jobs_exp);
        chk("sb_empty", exp_q.size(), 0);
        chk("inflight_end", o_inflight, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        i_rst        = 1'b1;
        cfg_rdy      = 1'b0;
        i_bgrid_step = '0;
        i_bgrid_end  = '0;
        #1;
        chk("rst_blk_rdy", blk_rdy, 0);
        chk("rst_bofs", o_bofs, 0);
        chk("rst_inflight", o_inflight, 0);
        chk("rst_done", done_dval, 0);
        chk("rst_err", o_err, 0);
        chk("rst_busy", o_busy, 0);
        tick();
        tick();
        i_rst = 1'b0;
        tick();

        // Basic 2D walk.
        track = 1'b1; auto_ret = 1'b1; ack_en = 1'b1;
        push_exp(0, 0, 0); push_exp(0, 3, 0); push_exp(2, 0, 0); push_exp(2, 3, 1);
        start_job(4, 6, 2, 3);
        wait_done();
        chk("basic_err", o_err, 0);

        // Partial last tile.
        push_exp(0, 0, 0); push_exp(0, 2, 0); push_exp(0, 4, 1);
        start_job(1, 5, 1, 2);
        wait_done();

        // Credit stall with no retires, then release one credit.
        auto_ret = 1'b0;
        for (int i = 0; i < 8; i++) push_exp(0, i, (i == 7));
        base = hs_count;
        start_job(1, 8, 1, 1);
        repeat (5) tick();
        chk("stall_acks", hs_count - base, 2);
        chk("stall_blk_rdy", blk_rdy, 0);
        chk("stall_inflight", o_inflight, 2);
        auto_ret = 1'b1;
        tick();
        auto_ret = 1'b0;
        chk("credit_inflight", o_inflight, 1);
        chk("credit_blk_rdy", blk_rdy, 1);
        tick();
        chk("credit_third_ack", hs_count - base, 3);
        auto_ret = 1'b1;
        wait_done();

        // Ack and retire together, then a retire in IDLE with nothing outstanding.
        track = 1'b0; auto_ret = 1'b0; ack_en = 1'b0;
        push_exp(0, 0, 0); push_exp(0, 1, 1);
        start_job(1, 2, 1, 1);
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        chk("sim_pre_inflight", o_inflight, 1);
        ack_en = 1'b1; man_done = 1'b1;
        tick();
        ack_en = 1'b0; man_done = 1'b0;
        chk("sim_inflight", o_inflight, 1);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        wait_done();
        chk("sim_err_clear", o_err, 0);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("idle_retire_err", o_err, 1);
        chk("idle_retire_cnt", o_inflight, 0);

        // Empty grid goes DRAIN then DONE.
        ack_en = 1'b1;
        start_job(0, 4, 1, 1);
        chk("empty_blk_rdy", blk_rdy, 0);
        chk("empty_done_early", done_dval, 0);
        chk("empty_busy", o_busy, 1);
        tick();
        chk("empty_done", done_dval, 1);
        tick();
        chk("empty_done_pulse", done_dval, 0);
        chk("empty_idle", o_busy, 0);
        chk("empty_done_count", dones_seen, jobs_exp);

        // Reset in the middle of a job.
        push_exp(0, 0, 0); push_exp(0, 3, 0);
        start_job(4, 6, 2, 3);
        repeat (4) tick();
        chk("mid_inflight", o_inflight, 2);
        chk("mid_blk_rdy", blk_rdy, 0);
        i_rst = 1'b1;
        #1;
        chk("arst_inflight", o_inflight, 0);
        chk("arst_bofs", o_bofs, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_err", o_err, 0);
        chk("arst_blk_rdy", blk_rdy, 0);
        chk("arst_blk_last", o_blk_last, 0);
        chk("arst_done", done_dval, 0);
        jobs_exp = jobs_exp - 1;
        tick();
        i_rst = 1'b0;
        tick();
        track = 1'b1; auto_ret = 1'b1;
        push_exp(0, 0, 0); push_exp(0, 3, 0); push_exp(2, 0, 0); push_exp(2, 3, 1);
        start_job(4, 6, 2, 3);
        wait_done();
        chk("post_rst_err", o_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
